// File: rtl/dma_pcie_mdma_c2h_axis_pkt_fifo.sv
// C2H AXI-Stream packet buffer: circular RAM feeding a prefetching output register,
// with cut-through or store-and-forward release, packet accounting and sticky error flags.
module dma_pcie_mdma_c2h_axis_pkt_fifo #(
  parameter int DATA_W  = 512,
  parameter int MTY_W   = $clog2(DATA_W / 8),
  parameter int CTRL_W  = 64,
  parameter int DEPTH   = 64,
  parameter bit SF_MODE = 1'b1
) (
  input  logic                   user_clk,
  input  logic                   user_reset_n,
  input  logic [DATA_W-1:0]      s_data,
  input  logic [CTRL_W-1:0]      s_ctrl,
  input  logic                   s_tlast,
  input  logic [MTY_W-1:0]       s_mty,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  output logic [DATA_W-1:0]      m_data,
  output logic [CTRL_W-1:0]      m_ctrl,
  output logic                   m_tlast,
  output logic [MTY_W-1:0]       m_mty,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [$clog2(DEPTH):0] level,
  output logic [$clog2(DEPTH):0] pkt_cnt,
  output logic                   err_oversize,
  output logic                   err_mty,
  input  logic                   clr_err
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW:0] cnt_t;
  localparam cnt_t FULL = cnt_t'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
    logic [MTY_W-1:0]  mty;
    logic              last;
  } beat_t;

  beat_t ram [DEPTH];
  beat_t in_beat;
  beat_t head;
  beat_t head_nxt;

  cnt_t wr_ptr;
  cnt_t rd_ptr;
  cnt_t rd_ptr_nxt;
  cnt_t level_nxt;
  cnt_t pkt_cnt_nxt;
  cnt_t remain;

  logic wr_en;
  logic rd_en;
  logic head_load;
  logic bypass;
  logic bypass_nxt;
  logic oversize;
  logic mty_bad;

  assign in_beat = '{data: s_data, ctrl: s_ctrl, mty: s_mty, last: s_tlast};

  assign wr_en    = s_tvalid && s_tready;
  assign rd_en    = m_tvalid && m_tready;
  assign oversize = SF_MODE && (level == FULL) && (pkt_cnt == '0);
  assign mty_bad  = wr_en && !s_tlast && (s_mty != '0);

  assign m_data  = head.data;
  assign m_ctrl  = head.ctrl;
  assign m_mty   = head.mty;
  assign m_tlast = head.last;

  // The output register always mirrors the oldest stored beat; when nothing older
  // remains after this cycle's read, the beat being written is forwarded directly.
  always_comb begin
    rd_ptr_nxt  = rd_ptr + cnt_t'(rd_en);
    level_nxt   = level + cnt_t'(wr_en) - cnt_t'(rd_en);
    pkt_cnt_nxt = pkt_cnt + cnt_t'(wr_en && s_tlast) - cnt_t'(rd_en && m_tlast);
    remain      = level - cnt_t'(rd_en);
    head_load   = (rd_en || (level == '0)) && (level_nxt != '0);
    head_nxt    = (remain == '0) ? in_beat : ram[rd_ptr_nxt[AW-1:0]];
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    bypass_nxt  = bypass;
    if (oversize) begin
      bypass_nxt = 1'b1;
    end else if (rd_en && m_tlast && (pkt_cnt_nxt == '0)) begin
      bypass_nxt = 1'b0;
    end
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      pkt_cnt      <= '0;
      bypass       <= 1'b0;
      head         <= '0;
      m_tvalid     <= 1'b0;
      s_tready     <= 1'b1;
      err_oversize <= 1'b0;
      err_mty      <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (wr_en) begin
        wr_ptr <= wr_ptr + cnt_t'(1);
      end
      rd_ptr  <= rd_ptr_nxt;
      level   <= level_nxt;
      pkt_cnt <= pkt_cnt_nxt;
      bypass  <= bypass_nxt;
      if (head_load) begin
        head <= head_nxt;
      end
      m_tvalid     <= (level_nxt != '0) && (!SF_MODE || (pkt_cnt_nxt != '0) || bypass_nxt);
      s_tready     <= (level_nxt != FULL);
      err_oversize <= oversize || (err_oversize && !clr_err);
      err_mty      <= mty_bad || (err_mty && !clr_err);
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and level define what is valid.
  always_ff @(posedge user_clk) begin
    if (wr_en) begin
      ram[wr_ptr[AW-1:0]] <= in_beat;
    end
  end

endmodule

// File: tb/tb_dma_pcie_mdma_c2h_axis_pkt_fifo.sv
// Directed bench: one store-and-forward and one cut-through instance (DATA_W=512, DEPTH=16),
// with a negedge monitor comparing every delivered beat against an expected queue.
module tb_dma_pcie_mdma_c2h_axis_pkt_fifo;

  localparam int DATA_W = 512;
  localparam int CTRL_W = 64;
  localparam int MTY_W  = 6;
  localparam int DEPTH  = 16;
  localparam int LW     = 5;

  typedef logic [639:0] val_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] s_data   = '0;
  logic [CTRL_W-1:0] s_ctrl   = '0;
  logic              s_tlast  = 1'b0;
  logic [MTY_W-1:0]  s_mty    = '0;
  logic              s_tvalid = 1'b0;
  logic              m_tready = 1'b0;
  logic              clr_err  = 1'b0;
  logic              sel      = 1'b1;

  logic              sf_s_tready, ct_s_tready, o_s_tready;
  logic [DATA_W-1:0] sf_m_data, ct_m_data, o_m_data;
  logic [CTRL_W-1:0] sf_m_ctrl, ct_m_ctrl, o_m_ctrl;
  logic              sf_m_tlast, ct_m_tlast, o_m_tlast;
  logic [MTY_W-1:0]  sf_m_mty, ct_m_mty, o_m_mty;
  logic              sf_m_tvalid, ct_m_tvalid, o_m_tvalid;
  logic [LW-1:0]     sf_level, ct_level, o_level;
  logic [LW-1:0]     sf_pkt_cnt, ct_pkt_cnt, o_pkt_cnt;
  logic              sf_err_oversize, ct_err_oversize, o_err_oversize;
  logic              sf_err_mty, ct_err_mty, o_err_mty;

  dma_pcie_mdma_c2h_axis_pkt_fifo #(
    .DATA_W(DATA_W), .MTY_W(MTY_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH), .SF_MODE(1'b1)
  ) u_sf (
    .user_clk(clk), .user_reset_n(rst_n),
    .s_data(s_data), .s_ctrl(s_ctrl), .s_tlast(s_tlast), .s_mty(s_mty),
    .s_tvalid(s_tvalid && sel), .s_tready(sf_s_tready),
    .m_data(sf_m_data), .m_ctrl(sf_m_ctrl), .m_tlast(sf_m_tlast), .m_mty(sf_m_mty),
    .m_tvalid(sf_m_tvalid), .m_tready(m_tready),
    .level(sf_level), .pkt_cnt(sf_pkt_cnt),
    .err_oversize(sf_err_oversize), .err_mty(sf_err_mty), .clr_err(clr_err)
  );

  dma_pcie_mdma_c2h_axis_pkt_fifo #(
    .DATA_W(DATA_W), .MTY_W(MTY_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH), .SF_MODE(1'b0)
  ) u_ct (
    .user_clk(clk), .user_reset_n(rst_n),
    .s_data(s_data), .s_ctrl(s_ctrl), .s_tlast(s_tlast), .s_mty(s_mty),
    .s_tvalid(s_tvalid && !sel), .s_tready(ct_s_tready),
    .m_data(ct_m_data), .m_ctrl(ct_m_ctrl), .m_tlast(ct_m_tlast), .m_mty(ct_m_mty),
    .m_tvalid(ct_m_tvalid), .m_tready(m_tready),
    .level(ct_level), .pkt_cnt(ct_pkt_cnt),
    .err_oversize(ct_err_oversize), .err_mty(ct_err_mty), .clr_err(clr_err)
  );

  assign o_s_tready     = sel ? sf_s_tready     : ct_s_tready;
  assign o_m_data       = sel ? sf_m_data       : ct_m_data;
  assign o_m_ctrl       = sel ? sf_m_ctrl       : ct_m_ctrl;
  assign o_m_tlast      = sel ? sf_m_tlast      : ct_m_tlast;
  assign o_m_mty        = sel ? sf_m_mty        : ct_m_mty;
  assign o_m_tvalid     = sel ? sf_m_tvalid     : ct_m_tvalid;
  assign o_level        = sel ? sf_level        : ct_level;
  assign o_pkt_cnt      = sel ? sf_pkt_cnt      : ct_pkt_cnt;
  assign o_err_oversize = sel ? sf_err_oversize : ct_err_oversize;
  assign o_err_mty      = sel ? sf_err_mty      : ct_err_mty;

  int   errors = 0;
  int   checks = 0;
  val_t exp_q[$];

  task automatic check(input string tag, input val_t got, input val_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk_data(input int id);
    return {16{32'hD000_0000 ^ 32'(id)}};
  endfunction

  function automatic logic [CTRL_W-1:0] mk_ctrl(input int id);
    return {32'hC7C7_0000 ^ 32'(id), ~32'(id)};
  endfunction

  function automatic val_t beat_of(input int id, input logic last, input logic [MTY_W-1:0] mty);
    return val_t'({mk_data(id), mk_ctrl(id), mty, last});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat and holds it until accepted; inputs change only just after an edge.
  task automatic send(input int id, input logic last, input logic [MTY_W-1:0] mty);
    bit acc = 1'b0;
    s_data   = mk_data(id);
    s_ctrl   = mk_ctrl(id);
    s_tlast  = last;
    s_mty    = mty;
    s_tvalid = 1'b1;
    for (int i = 0; i < 40 && !acc; i++) begin
      acc = o_s_tready;
      if (acc) exp_q.push_back(beat_of(id, last, mty));
      step();
    end
    s_tvalid = 1'b0;
    if (!acc) check("send_timeout", val_t'(0), val_t'(1));
  endtask

  task automatic drain(input string tag);
    m_tready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (o_level == '0 && !o_m_tvalid) break;
      step();
    end
    check(tag, val_t'(o_level), val_t'(0));
    check({tag, "_queue"}, val_t'(exp_q.size()), val_t'(0));
  endtask

  always @(negedge clk) begin
    if (rst_n && o_m_tvalid && m_tready) begin
      if (exp_q.size() == 0) check("mon_unexpected_beat", val_t'(1), val_t'(0));
      else check("mon_beat", val_t'({o_m_data, o_m_ctrl, o_m_mty, o_m_tlast}), exp_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();

    // Reset state
    check("rst_level",    val_t'(o_level),        val_t'(0));
    check("rst_pkt_cnt",  val_t'(o_pkt_cnt),      val_t'(0));
    check("rst_m_tvalid", val_t'(o_m_tvalid),     val_t'(0));
    check("rst_s_tready", val_t'(o_s_tready),     val_t'(1));
    check("rst_err_ovs",  val_t'(o_err_oversize), val_t'(0));
    check("rst_err_mty",  val_t'(o_err_mty),      val_t'(0));
    check("rst_m_beat",   val_t'({o_m_data, o_m_ctrl, o_m_mty, o_m_tlast}), val_t'(0));
    check("rst_ct_ready", val_t'(ct_s_tready),    val_t'(1));

    // 1: store-and-forward, 3-beat packet, last mty=5
    sel = 1'b1;
    m_tready = 1'b1;
    send(1, 1'b0, 6'h00);
    check("t1_hold_b0", val_t'(o_m_tvalid), val_t'(0));
    send(2, 1'b0, 6'h00);
    check("t1_hold_b1", val_t'(o_m_tvalid), val_t'(0));
    send(3, 1'b1, 6'h05);
    check("t1_release", val_t'(o_m_tvalid), val_t'(1));
    check("t1_pkt_one", val_t'(o_pkt_cnt),  val_t'(1));
    step();
    check("t1_stream",  val_t'(o_m_tvalid), val_t'(1));
    step();
    check("t1_last_mty", val_t'(o_m_mty),   val_t'(6'h05));
    check("t1_last_flg", val_t'(o_m_tlast), val_t'(1));
    step();
    check("t1_pkt_zero", val_t'(o_pkt_cnt),  val_t'(0));
    check("t1_idle",     val_t'(o_m_tvalid), val_t'(0));
    check("t1_no_mty_err", val_t'(o_err_mty), val_t'(0));
    drain("t1_drain");

    // 2: cut-through, 8 beats held back for 10 cycles
    sel = 1'b0;
    m_tready = 1'b0;
    send(100, 1'b0, 6'h00);
    check("t2_ct_latency", val_t'(o_m_tvalid), val_t'(1));
    for (int k = 1; k < 8; k++) send(100 + k, k == 7, 6'h00);
    step();
    step();
    check("t2_level8",  val_t'(o_level),    val_t'(8));
    check("t2_hold_b0", val_t'(o_m_data),   val_t'(mk_data(100)));
    check("t2_valid",   val_t'(o_m_tvalid), val_t'(1));
    m_tready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("t2_no_gap", val_t'(o_m_tvalid), val_t'(1));
      step();
    end
    check("t2_empty", val_t'(o_m_tvalid), val_t'(0));
    drain("t2_drain");

    // 3: store-and-forward oversize packet of 20 beats
    sel = 1'b1;
    m_tready = 1'b1;
    for (int k = 0; k < 16; k++) send(200 + k, 1'b0, 6'h00);
    check("t3_full",      val_t'(o_level),        val_t'(16));
    check("t3_not_ready", val_t'(o_s_tready),     val_t'(0));
    check("t3_no_valid",  val_t'(o_m_tvalid),     val_t'(0));
    check("t3_no_err",    val_t'(o_err_oversize), val_t'(0));
    s_data = mk_data(216); s_ctrl = mk_ctrl(216); s_tlast = 1'b0; s_mty = '0; s_tvalid = 1'b1;
    step();
    check("t3_err_set",   val_t'(o_err_oversize), val_t'(1));
    check("t3_bypass",    val_t'(o_m_tvalid),     val_t'(1));
    check("t3_level",     val_t'(o_level),        val_t'(16));
    for (int k = 16; k < 20; k++) send(200 + k, k == 19, 6'h00);
    drain("t3_drain");
    check("t3_sticky",    val_t'(o_err_oversize), val_t'(1));
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("t3_cleared",   val_t'(o_err_oversize), val_t'(0));
    send(230, 1'b0, 6'h00);
    check("t3_bypass_off", val_t'(o_m_tvalid), val_t'(0));
    send(231, 1'b1, 6'h00);
    check("t3_sf_again",   val_t'(o_m_tvalid), val_t'(1));
    drain("t3_drain2");

    // 4: cut-through full boundary and pointer wrap across three fills
    sel = 1'b0;
    for (int f = 0; f < 3; f++) begin
      m_tready = 1'b0;
      for (int k = 0; k < 16; k++) send(400 + f * 20 + k, k == 15, 6'h00);
      check("t4_full_level", val_t'(o_level),    val_t'(16));
      check("t4_full_ready", val_t'(o_s_tready), val_t'(0));
      if (f == 0) begin
        m_tready = 1'b1;
        step();
        m_tready = 1'b0;
        check("t4_one_read", val_t'(o_level),    val_t'(15));
        check("t4_reready",  val_t'(o_s_tready), val_t'(1));
      end
      drain("t4_drain");
    end

    // 5: illegal mty on a non-last beat
    sel = 1'b0;
    m_tready = 1'b1;
    send(500, 1'b0, 6'h3F);
    check("t5_err_set", val_t'(o_err_mty), val_t'(1));
    send(501, 1'b1, 6'h00);
    clr_err = 1'b1;
    send(502, 1'b0, 6'h3F);
    clr_err = 1'b0;
    check("t5_set_wins", val_t'(o_err_mty), val_t'(1));
    send(503, 1'b1, 6'h00);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("t5_cleared", val_t'(o_err_mty), val_t'(0));
    drain("t5_drain");

    // 6: reset with a partial store-and-forward packet held
    sel = 1'b1;
    m_tready = 1'b0;
    for (int k = 0; k < 5; k++) send(600 + k, 1'b0, 6'h00);
    check("t6_level5", val_t'(o_level), val_t'(5));
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("t6_rst_level",  val_t'(o_level),    val_t'(0));
    check("t6_rst_pkt",    val_t'(o_pkt_cnt),  val_t'(0));
    check("t6_rst_ready",  val_t'(o_s_tready), val_t'(1));
    check("t6_rst_valid",  val_t'(o_m_tvalid), val_t'(0));
    check("t6_rst_beat",   val_t'({o_m_data, o_m_ctrl, o_m_mty, o_m_tlast}), val_t'(0));
    check("t6_rst_errs",   val_t'({o_err_oversize, o_err_mty, ct_err_mty}), val_t'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    m_tready = 1'b1;
    send(610, 1'b1, 6'h07);
    check("t6_valid",  val_t'(o_m_tvalid), val_t'(1));
    check("t6_level1", val_t'(o_level),    val_t'(1));
    drain("t6_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_pcie_mdma_c2h_axis_pkt_fifo.md
# dma_pcie_mdma_c2h_axis_pkt_fifo

Parametrised C2H AXI-Stream buffer inserted between the user C2H source and the QDMA C2H stream port. It carries the same beat content as the C2H stream interface: data, ctrl, tlast, mty, tvalid and tready. Data width, control width and depth are generalised, and the block adds selectable cut-through or store-and-forward release, packet accounting, and error detection for oversize packets and illegal mty.

## Interface
- DATA_W, 512: data bus width in bits; one of 64, 128, 256 or 512.
- MTY_W, $clog2(DATA_W/8): empty-byte count width.
- CTRL_W, 64: width of the per-beat ctrl sideband, stored verbatim.
- DEPTH, 64: buffer depth in beats; a power of 2, at least 4.
- SF_MODE, 1: 1 selects store-and-forward, 0 selects cut-through.
- user_clk  in  1  sole clock.
- user_reset_n  in  1  asynchronous, active-low reset.
- s_data  in  DATA_W  upstream beat data.
- s_ctrl  in  CTRL_W  upstream ctrl sideband.
- s_tlast  in  1  last beat of packet.
- s_mty  in  MTY_W  empty bytes in the last beat.
- s_tvalid  in  1  upstream valid.
- s_tready  out  1  equals (level != DEPTH).
- m_data / m_ctrl / m_tlast / m_mty  out  as s_*  downstream beat.
- m_tvalid  out  1  downstream valid.
- m_tready  in  1  downstream ready.
- level  out  $clog2(DEPTH)+1  beats currently stored.
- pkt_cnt  out  $clog2(DEPTH)+1  complete packets stored, i.e. tlast beats held.
- err_oversize  out  1  sticky: a store-and-forward packet exceeded DEPTH.
- err_mty  out  1  sticky: nonzero mty seen on a non-last beat.
- clr_err  in  1  single-cycle pulse that clears both sticky errors.

## Operation
- Storage is a circular RAM of DEPTH entries, each DATA_W+CTRL_W+MTY_W+1 bits wide. The write and read pointers are $clog2(DEPTH)+1 bits and use the extra MSB for full/empty wrap detection.
- A write occurs when s_tvalid && s_tready. A read occurs when m_tvalid && m_tready. Both may happen in the same cycle, giving level unchanged.
- A write while full is impossible because s_tready is low. A write and a read in the same cycle while full is not accepted; s_tready stays low for that cycle.
- pkt_cnt increments on a write with s_tlast and decrements on a read with m_tlast. If both happen in the same cycle, pkt_cnt is unchanged.
- Release rules:
  - Cut-through (SF_MODE=0): m_tvalid = (level != 0).
  - Store-and-forward (SF_MODE=1): m_tvalid = (pkt_cnt != 0) || bypass.
- Oversize handling in store-and-forward mode:
  - When level == DEPTH and pkt_cnt == 0, set err_oversize and set bypass.
  - While bypass is set, the block behaves as cut-through.
  - bypass clears when the read of a tlast beat brings pkt_cnt to 0 with no other stored tlast.
  - The packet is forwarded intact, never dropped.
- mty check: a write with !s_tlast and s_mty != 0 sets err_mty. The beat is stored and forwarded unchanged.
- clr_err clears both sticky bits. If an error condition occurs in the same cycle, set wins.
- Beat content, including ctrl, is passed through bit-exact in order. There is no reordering and no modification.

## Timing
- Reset values: level=0, pkt_cnt=0, m_tvalid=0, s_tready=1, err_oversize=0, err_mty=0, bypass=0. m_data, m_ctrl, m_mty and m_tlast are 0. Reset asserted mid-packet discards all contents immediately and asynchronously.
- Outputs are registered. m_* comes from a one-entry output register fed by the RAM read, with prefetch so that back-to-back reads sustain 1 beat per cycle.
- Cut-through latency: a beat written in cycle N appears with m_tvalid=1 in cycle N+1, when the block is empty and m_tready=1.
- Store-and-forward latency: the first beat of a packet is presented in cycle N+1, where N is the cycle its tlast beat is written.
- level and pkt_cnt update in the cycle after the corresponding handshake.
- s_tready is driven from registered level. It deasserts in the cycle after the write that fills the buffer, and reasserts in the cycle after the first read from full.
- m_* is held stable while m_tvalid && !m_tready, per the AXI-Stream rule. m_tvalid is never withdrawn without a handshake.
- err_oversize sets in the cycle after the full-with-no-tlast condition is registered.
- Throughput: 1 beat/cycle sustained in and out, when neither side stalls.

## Test plan
All scenarios use DATA_W=512 and DEPTH=16.

1. Store-and-forward, 3-beat packet with mty=0x05 on the last beat, m_tready=1: m_tvalid stays 0 until the cycle after the tlast write. Then 3 beats stream out on consecutive cycles with last mty=0x05 and ctrl identical to input. pkt_cnt goes 1 then 0.
2. Cut-through, 8 beats with m_tready=0 for 10 cycles: level reaches 8 and m_data holds beat 0 stable. After release, 8 beats come out in order with no gaps.
3. Store-and-forward, 20-beat packet: at level=16 with pkt_cnt=0, err_oversize=1 and m_tvalid rises. All 20 beats are delivered intact. clr_err clears err_oversize.
4. Full boundary, cut-through: 16 beats written with m_tready=0, so s_tready=0 and level=16. A single read brings level to 15, and s_tready=1 the next cycle. Pointer wrap is verified across 3 fills.
5. mty=0x3F on a non-last beat: err_mty=1 and the beat is forwarded unchanged. clr_err and a new violation in the same cycle leave err_mty=1.
6. Reset mid-packet with 5 beats stored: all outputs return to reset values within the reset assertion. A following 1-beat packet is delivered correctly.
